// File: rtl/tx_uart_fifo.sv
// tx_uart_fifo: UART transmitter with a small input FIFO.
//   Frames are start(0), DATA_WIDTH payload bits LSB first, an optional
//   parity bit (even/odd), and 1 or 2 stop bits (1). Bit timing comes from a
//   one-cycle baud_clk tick; state and serial_out change only on tick edges.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   baud_clk     - one-clk-cycle tick per bit period
//   i_valid      - source presents a word on i_data
//   i_data       - payload word, captured when i_valid & o_ready
//   o_ready      - FIFO not full
//   o_busy       - frame in progress or FIFO non-empty (registered)
//   o_tx_done    - one-cycle pulse when a frame's last stop bit ends
//   o_fifo_count - FIFO occupancy
//   serial_out   - serial line, idle high, registered
module tx_uart_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                baud_clk,
  input  logic                                i_valid,
  input  logic [DATA_WIDTH-1:0]               i_data,
  output logic                                o_ready,
  output logic                                o_busy,
  output logic                                o_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_count,
  output logic                                serial_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_INV   = (PARITY_MODE == 2);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("tx_uart_fifo: DATA_WIDTH must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("tx_uart_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("tx_uart_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("tx_uart_fifo: FIFO_DEPTH must be a power of 2 in 2..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // FIFO storage
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Transmitter
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  parity_q, parity_d;
  logic                  ser_q, ser_d;
  logic                  tx_done_q, tx_done_d;
  logic                  busy_q, busy_d;

  logic                  push;
  logic                  pop;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] head_word;

  assign head_word = mem_q[rd_ptr_q];
  assign push      = i_valid && (count_q != FULL);
  assign frame_end = baud_clk && (state_q == STOP) && (stop_cnt_q == LAST_STOP);
  // Pop looks at pre-edge occupancy, so a word pushed this cycle waits a cycle.
  assign pop       = (count_q != '0) &&
                     ((baud_clk && (state_q == IDLE)) || frame_end);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    ser_d      = ser_q;
    tx_done_d  = 1'b0;

    if (baud_clk) begin
      unique case (state_q)
        IDLE: begin
          ser_d = 1'b1;
        end
        START: begin
          ser_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_MODE != 0) begin
              ser_d   = parity_q;
              state_d = PARITY;
            end else begin
              ser_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            ser_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        PARITY: begin
          ser_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_done_d = 1'b1;
            ser_d     = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: begin
          ser_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    // A pop only happens from IDLE or at the end of the last stop bit; both
    // start a new frame, so the load overrides whatever the case chose.
    if (pop) begin
      shift_d  = head_word;
      parity_d = (^head_word) ^ ODD_INV;
      ser_d    = 1'b0;
      state_d  = START;
    end

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      ser_q      <= 1'b1;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      ser_q      <= ser_d;
      tx_done_q  <= tx_done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_ready      = (count_q != FULL);
  assign o_busy       = busy_q;
  assign o_tx_done    = tx_done_q;
  assign o_fifo_count = count_q;
  assign serial_out   = ser_q;

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Directed bench for tx_uart_fifo: three instances (8N1, 7O2, 8E1), all with
// a 4-entry FIFO, sharing clock, reset and baud tick.
module tb_tx_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       baud;
  logic       v0, v1, v2;
  logic [7:0] d0, d2;
  logic [6:0] d1;

  logic       rdy  [3];
  logic       busy [3];
  logic       done [3];
  logic       ser  [3];
  logic [2:0] cnt  [3];

  int nchk = 0;
  int nerr = 0;
  int done_cnt = 0;
  int sel = 0;

  logic       rdy_m, busy_m, done_m, ser_m;
  logic [2:0] cnt_m;

  always_comb begin
    rdy_m  = rdy[sel];
    busy_m = busy[sel];
    done_m = done[sel];
    ser_m  = ser[sel];
    cnt_m  = cnt[sel];
  end

  tx_uart_fifo #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset(reset), .baud_clk(baud), .i_valid(v0), .i_data(d0),
    .o_ready(rdy[0]), .o_busy(busy[0]), .o_tx_done(done[0]),
    .o_fifo_count(cnt[0]), .serial_out(ser[0]));

  tx_uart_fifo #(.DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
    .clk(clk), .reset(reset), .baud_clk(baud), .i_valid(v1), .i_data(d1),
    .o_ready(rdy[1]), .o_busy(busy[1]), .o_tx_done(done[1]),
    .o_fifo_count(cnt[1]), .serial_out(ser[1]));

  tx_uart_fifo #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset(reset), .baud_clk(baud), .i_valid(v2), .i_data(d2),
    .o_ready(rdy[2]), .o_busy(busy[2]), .o_tx_done(done[2]),
    .o_fifo_count(cnt[2]), .serial_out(ser[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given baud level; returns #1 after the edge.
  task automatic step(input logic b);
    baud = b;
    @(posedge clk);
    #1;
    if (done_m === 1'b1) done_cnt++;
  endtask

  // bits[n-1] is the first bit on the line; one tick then `gap` idle clocks.
  task automatic expect_frame(input string tag, input int gap,
                              input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1);
      chk(tag, ser_m, bits[i]);
      repeat (gap) step(1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    baud  = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ser", ser_m, 1'b1);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_rdy", rdy_m, 1'b1);
    chk("rst_cnt", cnt_m, 3'd0);
    chk("rst_done", done_m, 1'b0);
    #2 reset = 1'b1;

    // Idle line under 50 ticks
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      chk("idle_ser", ser_m, 1'b1);
      chk("idle_busy", busy_m, 1'b0);
      chk("idle_rdy", rdy_m, 1'b1);
      chk("idle_cnt", cnt_m, 3'd0);
      step(1'b0);
    end

    // 8N1 0xA5, tick every 16 clocks; data changed after push must not matter
    done_cnt = 0;
    v0 = 1'b1; d0 = 8'hA5;
    step(1'b0);
    v0 = 1'b0; d0 = 8'hFF;
    chk("a5_busy_after_push", busy_m, 1'b1);
    chk("a5_cnt_after_push", cnt_m, 3'd1);
    chk("a5_ser_after_push", ser_m, 1'b1);
    expect_frame("a5_bit", 15, 16'b0101001011, 10);
    chk("a5_busy_in_stop", busy_m, 1'b1);
    chk("a5_done_before_end", done_cnt, 0);
    step(1'b1);
    chk("a5_done_pulse", done_m, 1'b1);
    chk("a5_busy_end", busy_m, 1'b0);
    chk("a5_ser_end", ser_m, 1'b1);
    repeat (5) step(1'b0);
    chk("a5_done_once", done_cnt, 1);

    // 7O2 0x55, tick every 4 clocks
    sel = 1;
    done_cnt = 0;
    v1 = 1'b1; d1 = 7'h55;
    step(1'b0);
    v1 = 1'b0;
    expect_frame("7o2_bit", 3, 16'b01010101111, 11);
    chk("7o2_done_before_end", done_cnt, 0);
    step(1'b1);
    chk("7o2_done_pulse", done_m, 1'b1);
    chk("7o2_busy_end", busy_m, 1'b0);
    step(1'b0);

    // FIFO fill: 5 back-to-back writes, 5th rejected, then 4 frames back-to-back
    sel = 0;
    done_cnt = 0;
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] w;
      w = 8'h11 * 8'(i + 1);
      d0 = w;
      chk("fill_rdy_before", rdy_m, (i < 4) ? 1'b1 : 1'b0);
      step(1'b0);
      chk("fill_cnt", cnt_m, (i < 4) ? 3'(i + 1) : 3'd4);
    end
    v0 = 1'b0;
    chk("fill_rdy_full", rdy_m, 1'b0);
    expect_frame("b2b_11", 0, 16'b0100010001, 10);
    expect_frame("b2b_22", 0, 16'b0010001001, 10);
    expect_frame("b2b_33", 0, 16'b0110011001, 10);
    expect_frame("b2b_44", 0, 16'b0001000101, 10);
    step(1'b1);
    chk("b2b_idle_ser", ser_m, 1'b1);
    chk("b2b_done_cnt", done_cnt, 4);
    chk("b2b_cnt", cnt_m, 3'd0);
    chk("b2b_busy", busy_m, 1'b0);
    step(1'b0);

    // Push on the same edge the last stop bit ends
    done_cnt = 0;
    v0 = 1'b1; d0 = 8'h3C;
    step(1'b0);
    v0 = 1'b0;
    expect_frame("edge_3c", 1, 16'b0001111001, 10);
    v0 = 1'b1; d0 = 8'hC3;
    step(1'b1);
    v0 = 1'b0;
    chk("edge_ser_idle", ser_m, 1'b1);
    chk("edge_cnt1", cnt_m, 3'd1);
    chk("edge_done", done_m, 1'b1);
    chk("edge_busy", busy_m, 1'b1);
    step(1'b0);
    step(1'b1);
    chk("edge_start", ser_m, 1'b0);
    chk("edge_cnt0", cnt_m, 3'd0);
    step(1'b0);
    expect_frame("edge_c3", 1, 16'b110000111, 9);
    step(1'b1);
    chk("edge_done2", done_m, 1'b1);
    chk("edge_busy_end", busy_m, 1'b0);
    step(1'b0);

    // 8E1 reset mid-frame with two words queued
    sel = 2;
    v2 = 1'b1; d2 = 8'h81;
    step(1'b0);
    d2 = 8'h7E;
    step(1'b0);
    v2 = 1'b0;
    chk("abort_cnt2", cnt_m, 3'd2);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("abort_bit1", ser_m, 1'b0);
    chk("abort_cnt1", cnt_m, 3'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ser", ser_m, 1'b1);
    chk("abort_cnt", cnt_m, 3'd0);
    chk("abort_done", done_m, 1'b0);
    chk("abort_busy", busy_m, 1'b0);
    chk("abort_rdy", rdy_m, 1'b1);
    done_cnt = 0;
    repeat (3) step(1'b1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_ser_hold", ser_m, 1'b1);
    #2 reset = 1'b1;
    step(1'b0);
    v2 = 1'b1; d2 = 8'h0F;
    step(1'b0);
    v2 = 1'b0;
    chk("e0f_cnt", cnt_m, 3'd1);
    expect_frame("e0f_bit", 1, 16'b01111000001, 11);
    step(1'b1);
    chk("e0f_done", done_m, 1'b1);
    chk("e0f_busy_end", busy_m, 1'b0);
    chk("e0f_done_once", done_cnt, 1);
    step(1'b0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
